// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer for a 22-bit LFSR noise source: seed load, handshake-gated advance, period check.
// Optional period checker enabled by defining LFSR_PERIOD_CHK_EN.
module lfsr_burst_ctrl #(
  parameter int unsigned WIDTH  = 22,
  parameter int unsigned LEN_W  = 24,
  parameter int unsigned PERIOD = 4194303
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             continuous,
  input  logic             abort,
  output logic             lfsr_load,
  output logic             lfsr_en,
  input  logic [WIDTH-1:0] lfsr_out,
  input  logic             lfsr_cycle,
  output logic [WIDTH-1:0] samp_data,
  output logic             samp_valid,
  input  logic             samp_ready,
  output logic             busy,
  output logic             done,
  output logic             period_err
);

  localparam int unsigned ADV_W = 23;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PRIME = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] remain, remain_nx;
  logic             cont, cont_nx;
  logic             start_acc;

  // State and burst bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      remain <= '0;
      cont   <= 1'b0;
    end else begin
      state  <= state_nx;
      remain <= remain_nx;
      cont   <= cont_nx;
    end
  end

  // Outputs decode from the state register so an async reset clears them at once
  always_comb begin
    state_nx   = state;
    remain_nx  = remain;
    cont_nx    = cont;
    start_acc  = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_en    = 1'b0;
    samp_valid = 1'b0;
    samp_data  = '0;
    done       = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          start_acc = 1'b1;
          remain_nx = burst_len;
          cont_nx   = continuous;
          state_nx  = (burst_len == '0 && !continuous) ? DONE : LOAD;
        end
      end
      LOAD: begin
        lfsr_load = 1'b1;
        state_nx  = abort ? DONE : PRIME;
      end
      PRIME: begin
        state_nx = abort ? DONE : RUN;
      end
      RUN: begin
        samp_valid = 1'b1;
        samp_data  = lfsr_out;
        lfsr_en    = samp_ready;
        if (samp_ready && !cont) begin
          if (remain != '0) remain_nx = remain - LEN_W'(1);
          if (remain == LEN_W'(1)) state_nx = DONE;
        end
        // A handshake in the abort cycle still counts; nothing is offered afterwards
        if (abort) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef LFSR_PERIOD_CHK_EN
  logic [ADV_W-1:0] adv_cnt;
  logic             armed;
  logic             perr;

  // First marker after load arms; later markers must land exactly PERIOD advances apart
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adv_cnt <= '0;
      armed   <= 1'b0;
      perr    <= 1'b0;
    end else begin
      if (start_acc) perr <= 1'b0;
      if (state == LOAD) begin
        adv_cnt <= '0;
        armed   <= 1'b0;
      end else if (lfsr_en) begin
        if (lfsr_cycle) begin
          if (armed && (adv_cnt + ADV_W'(1)) != ADV_W'(PERIOD)) perr <= 1'b1;
          armed   <= 1'b1;
          adv_cnt <= '0;
        end else if (adv_cnt != '1) begin
          adv_cnt <= adv_cnt + ADV_W'(1);
        end else if (armed) begin
          perr <= 1'b1;
        end
      end
    end
  end

  assign period_err = perr;
`else
  logic unused_chk;
  assign unused_chk = ^{lfsr_cycle, start_acc, ADV_W'(PERIOD)};
  assign period_err = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Directed bench for lfsr_burst_ctrl with a stub LFSR and a sample scoreboard.
module tb_lfsr_burst_ctrl;
  localparam int unsigned WIDTH  = 22;
  localparam int unsigned LEN_W  = 24;
  localparam int unsigned PERIOD = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic             continuous = 1'b0;
  logic             abort = 1'b0;
  logic             samp_ready = 1'b0;
  logic             lfsr_load, lfsr_en, lfsr_cycle;
  logic [WIDTH-1:0] lfsr_out, samp_data;
  logic             samp_valid, busy, done, period_err;

  int errors = 0;
  int checks = 0;
  int n_en = 0, n_load = 0, n_valid = 0, n_hs = 0;
  int mark_n = 15;
  int stub_cnt;
  logic [WIDTH-1:0] seed = 22'h1ACE5;
  logic [WIDTH-1:0] q[$];

  lfsr_burst_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .PERIOD(PERIOD)) dut (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
    .continuous(continuous), .abort(abort), .lfsr_load(lfsr_load),
    .lfsr_en(lfsr_en), .lfsr_out(lfsr_out), .lfsr_cycle(lfsr_cycle),
    .samp_data(samp_data), .samp_valid(samp_valid), .samp_ready(samp_ready),
    .busy(busy), .done(done), .period_err(period_err)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1] ^ x[WIDTH-2]};
  endfunction

  // Stub LFSR with a period marker every mark_n advances
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_out <= '0;
      stub_cnt <= 0;
    end else if (lfsr_load) begin
      lfsr_out <= seed;
      stub_cnt <= 0;
    end else if (lfsr_en) begin
      lfsr_out <= lfsr_next(lfsr_out);
      stub_cnt <= (stub_cnt >= mark_n - 1) ? 0 : stub_cnt + 1;
    end
  end
  assign lfsr_cycle = (stub_cnt == mark_n - 1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every handshake
  always @(negedge clk) begin
    if (reset) begin
      if (lfsr_en) n_en++;
      if (lfsr_load) n_load++;
      if (samp_valid) n_valid++;
      if (samp_valid && samp_ready) begin
        n_hs++;
        if (q.size() == 0) chk("sb_unexpected_sample", 32'(samp_data), 32'hFFFFFFFF);
        else chk("sb_sample", 32'(samp_data), 32'(q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int n);
    logic [WIDTH-1:0] s;
    s = seed;
    for (int i = 0; i < n; i++) begin
      q.push_back(s);
      s = lfsr_next(s);
    end
  endtask

  task automatic go(input int len, input logic cont);
    burst_len  = LEN_W'(len);
    continuous = cont;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    continuous = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < budget) begin
      tick();
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(done), 32'd1);
    tick();
  endtask

  task automatic abort_run(input logic rdy, input string tag);
    int h0;
    seed = rdy ? 22'h2F00D : 22'h0BEEF;
    push_exp(rdy ? 4 : 3);
    h0 = n_hs;
    samp_ready = 1'b1;
    go(10, 1'b0);
    tick(); tick();
    for (int i = 0; i < 3; i++) tick();
    samp_ready = rdy;
    abort = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_in_abort"}, 32'(samp_valid), 32'd1);
    tick();
    abort = 1'b0;
    samp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_valid_off"}, 32'(samp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_samples"}, 32'(n_hs - h0), rdy ? 32'd4 : 32'd3);
    tick();
  endtask

  task automatic cont_run(input int mark, input int n, input logic [WIDTH-1:0] sd);
    mark_n = mark;
    seed = sd;
    push_exp(n);
    samp_ready = 1'b1;
    go(0, 1'b1);
    tick(); tick();
    for (int i = 0; i < n; i++) tick();
    samp_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("cont_done", 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, l0, v0, h0;
    logic [6:0] pat;
    logic [WIDTH-1:0] prev;
    logic exp_err;

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(samp_valid), 32'd0);
    chk("rst_load", 32'(lfsr_load), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(period_err), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Basic burst of 5 with ready held high
    e0 = n_en; l0 = n_load; v0 = n_valid; h0 = n_hs;
    push_exp(5);
    samp_ready = 1'b1;
    go(5, 1'b0);
    @(negedge clk);
    chk("t1_load_p1", 32'(lfsr_load), 32'd1);
    chk("t1_busy_p1", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_load_p2", 32'(lfsr_load), 32'd0);
    chk("t1_valid_p2", 32'(samp_valid), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_valid_run", 32'(samp_valid), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_valid_done", 32'(samp_valid), 32'd0);
    chk("t1_busy_done", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_done_off", 32'(done), 32'd0);
    chk("t1_en_cnt", 32'(n_en - e0), 32'd5);
    chk("t1_load_cnt", 32'(n_load - l0), 32'd1);
    chk("t1_valid_cnt", 32'(n_valid - v0), 32'd5);
    chk("t1_hs_cnt", 32'(n_hs - h0), 32'd5);
    tick();

    // Burst of 4 under a stalling consumer
    seed = 22'h155AA;
    e0 = n_en;
    push_exp(4);
    pat = 7'b1101001;
    prev = '0;
    samp_ready = 1'b0;
    go(4, 1'b0);
    tick(); tick();
    for (int i = 0; i < 7; i++) begin
      samp_ready = pat[i];
      @(negedge clk);
      chk("t2_en_eq_ready", 32'(lfsr_en), 32'(pat[i]));
      if (i > 0 && !pat[i-1]) chk("t2_stall_stable", 32'(samp_data), 32'(prev));
      prev = samp_data;
      tick();
    end
    samp_ready = 1'b0;
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_en_cnt", 32'(n_en - e0), 32'd4);
    tick(); tick();

    // Zero-length burst, then start+abort together
    l0 = n_load; v0 = n_valid;
    go(0, 1'b0);
    @(negedge clk);
    chk("t3_done_p1", 32'(done), 32'd1);
    chk("t3_no_load", 32'(lfsr_load), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_load_cnt", 32'(n_load - l0), 32'd0);
    chk("t3_valid_cnt", 32'(n_valid - v0), 32'd0);
    abort = 1'b1;
    go(3, 1'b0);
    abort = 1'b0;
    @(negedge clk);
    chk("t3_abort_busy", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_abort_busy2", 32'(busy), 32'd0);
    chk("t3_abort_load", 32'(n_load - l0), 32'd0);
    tick();

    // Abort after three samples, ready low then high in the abort cycle
    abort_run(1'b0, "t4a");
    abort_run(1'b1, "t4b");

    // Continuous stream period check: correct markers, then short markers
    cont_run(15, 40, 22'h3C3C3);
    @(negedge clk);
    chk("t5_err_good", 32'(period_err), 32'd0);
    tick();
    cont_run(14, 40, 22'h12345);
`ifdef LFSR_PERIOD_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk);
    chk("t5_err_bad", 32'(period_err), 32'(exp_err));
    chk("t5_idle", 32'(busy), 32'd0);
    tick(); tick();
    @(negedge clk);
    chk("t5_err_held", 32'(period_err), 32'(exp_err));
    tick();
    mark_n = 15;
    seed = 22'h0F0F0;
    push_exp(2);
    samp_ready = 1'b1;
    go(2, 1'b0);
    @(negedge clk);
    chk("t5_err_cleared", 32'(period_err), 32'd0);
    wait_done("t5_burst_done", 10);

    // Asynchronous reset mid-RUN
    seed = 22'h2A5A5;
    push_exp(10);
    samp_ready = 1'b1;
    go(10, 1'b0);
    tick(); tick(); tick();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid_async", 32'(samp_valid), 32'd0);
    chk("t6_en_async", 32'(lfsr_en), 32'd0);
    chk("t6_busy_async", 32'(busy), 32'd0);
    q.delete();
    tick(); tick();
    reset = 1'b1;
    tick();
    seed = 22'h1F00F;
    push_exp(2);
    go(2, 1'b0);
    @(negedge clk);
    chk("t6_load_after_rst", 32'(lfsr_load), 32'd1);
    tick(); tick();
    @(negedge clk);
    chk("t6_valid_after_rst", 32'(samp_valid), 32'd1);
    wait_done("t6_done", 10);
    samp_ready = 1'b0;
    tick();
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
